// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings and arbiter FSM states for the master arbiter.
package ahb3lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR,
      ST_RSP_ERR
   } arb_state_t;

   // A request is legal when its size fits the bus and its address is size-aligned.
   function automatic logic req_legal(input logic [2:0] size,
                                      input logic [2:0] max_size,
                                      input logic [2:0] addr_lsb);
      logic [7:0] mask;
      mask = (8'd1 << size) - 8'd1;
      return (size <= max_size) && ((addr_lsb & mask[2:0]) == 3'b000);
   endfunction

endpackage

// File: rtl/ahb3lite_master_arbiter_if.sv
// AHB-Lite master-side bus bundle; master modport drives the address/data phase.
interface ahb3lite_master_arbiter_if #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
);
   logic                  HSEL;
   logic [HADDR_SIZE-1:0] HADDR;
   logic [HDATA_SIZE-1:0] HWDATA;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [1:0]            HTRANS;
   logic                  HMASTLOCK;
   logic [HDATA_SIZE-1:0] HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_req_arbiter.sv
// Request selector: one-hot grant plus index. AHB_ARB_RR_EN selects round-robin,
// otherwise fixed priority (lowest index wins) with no pointer register.
module ahb_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic found;

`ifdef AHB_ARB_RR_EN
   logic [IDX_W-1:0] ptr;
   int               cand;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ptr <= IDX_W'(NUM_REQ - 1);
      end else if (accept) begin
         ptr <= grant_idx;
      end
   end

   // Search starts one past the last winner and wraps.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!found && req_valid[IDX_W'(cand)]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(cand);
         end
      end
      grant = '0;
      if (found) grant[grant_idx] = 1'b1;
   end
`else
   logic unused_rr_inputs;
   assign unused_rr_inputs = ^{HCLK, HRESETn, accept};

   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
      grant = '0;
      if (found) grant[grant_idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/ahb3lite_master_arbiter.sv
// Shares one AHB-Lite master port between NUM_REQ requesters, one single transfer
// at a time. Arbitration mode is set by AHB_ARB_RR_EN (see ahb_req_arbiter).
//
// state      | meaning
// IDLE       | arbitrate, accept and latch the winning request
// ADDR       | address phase (NONSEQ) until HREADY
// DATA       | data phase, HWDATA held until HREADY
// ERR        | second cycle of an ERROR response
// RSP_ERR    | illegal request, error response without bus activity
module ahb3lite_master_arbiter
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                                HCLK,
   input  logic                                HRESETn,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0]                  req_write,
   input  logic [NUM_REQ-1:0][HADDR_SIZE-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][HDATA_SIZE-1:0]  req_wdata,
   input  logic [NUM_REQ-1:0][2:0]             req_size,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [HDATA_SIZE-1:0]               rsp_rdata,
   output logic                                rsp_err,
   ahb3lite_master_arbiter_if.master           ahb
);

   localparam int         IDX_W    = $clog2(NUM_REQ);
   localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

   arb_state_t            state, state_nxt;
   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grant_idx, win_idx;
   logic                  accept, done, done_err;
   logic [HADDR_SIZE-1:0] lat_addr;
   logic [HDATA_SIZE-1:0] lat_wdata;
   logic                  lat_write;
   logic [2:0]            lat_size;

   ahb_req_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_valid (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Gating with HRESETn keeps req_ready at its reset value while reset is held.
   assign accept    = (state == ST_IDLE) && HRESETn && (|req_valid);
   assign req_ready = accept ? grant : '0;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      done_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = req_legal(req_size[grant_idx], MAX_SIZE, req_addr[grant_idx][2:0])
                         ? ST_ADDR : ST_RSP_ERR;
            end
         end
         ST_ADDR: begin
            if (ahb.HREADY) state_nxt = ST_ADDR == ST_ADDR ? ST_DATA : ST_IDLE;
         end
         ST_DATA: begin
            if (ahb.HREADY) begin
               state_nxt = ST_IDLE;
               done      = 1'b1;
               done_err  = ahb.HRESP;
            end else if (ahb.HRESP) begin
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            if (ahb.HREADY) begin
               state_nxt = ST_IDLE;
               done      = 1'b1;
               done_err  = 1'b1;
            end
         end
         ST_RSP_ERR: begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
            done_err  = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ahb.HSEL      = (state == ST_ADDR);
      ahb.HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      ahb.HADDR     = (state == ST_ADDR) ? lat_addr : '0;
      ahb.HWRITE    = (state == ST_ADDR) && lat_write;
      ahb.HSIZE     = (state == ST_ADDR) ? lat_size : '0;
      ahb.HWDATA    = (state == ST_DATA && lat_write) ? lat_wdata : '0;
      ahb.HBURST    = HBURST_SINGLE;
      ahb.HPROT     = HPROT_DEFAULT;
      ahb.HMASTLOCK = 1'b0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         win_idx   <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_write <= 1'b0;
         lat_size  <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= '0;
         rsp_err   <= done && done_err;
         if (accept) begin
            win_idx   <= grant_idx;
            lat_addr  <= req_addr[grant_idx];
            lat_wdata <= req_wdata[grant_idx];
            lat_write <= req_write[grant_idx];
            lat_size  <= req_size[grant_idx];
         end
         if (done) begin
            rsp_valid[win_idx] <= 1'b1;
            if (!done_err && !lat_write) rsp_rdata <= ahb.HRDATA;
         end
      end
   end

endmodule

// File: doc/ahb3lite_master_arbiter.md
# ahb3lite_master_arbiter

Shares one AHB-Lite master port between `NUM_REQ` requesters, each with a simple valid/ready request and response interface. It arbitrates between pending requests and latches the winner. It then sequences one single (non-burst) transfer through the AHB address and data phases, handling HREADY wait states and the two-cycle ERROR response. The block sits between on-chip request sources (test sequencers, DMA, CPU shim) and the AHB-Lite slave/memory.

## Interface
- `HADDR_SIZE`, 32, address width
- `HDATA_SIZE`, 32, data width (32 or 64)
- `NUM_REQ`, 2, number of requesters (2..8)

- `HCLK` in 1: clock, all logic on rising edge
- `HRESETn` in 1: reset, asynchronous, active-low
- `req_valid` in [NUM_REQ]: request pending per requester
- `req_ready` out [NUM_REQ]: one-hot accept pulse
- `req_write` in [NUM_REQ]: 1 = write
- `req_addr` in [NUM_REQ][HADDR_SIZE]: byte address
- `req_wdata` in [NUM_REQ][HDATA_SIZE]: write data, lane-placed by requester
- `req_size` in [NUM_REQ][3]: HSIZE encoding
- `rsp_valid` out [NUM_REQ]: one-hot completion pulse
- `rsp_rdata` out HDATA_SIZE: read data, shared, valid with `rsp_valid`
- `rsp_err` out 1: error flag, valid with `rsp_valid`
- `HSEL` out 1, `HADDR` out HADDR_SIZE, `HWDATA` out HDATA_SIZE, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HPROT` out 4, `HTRANS` out 2, `HMASTLOCK` out 1: AHB-Lite master outputs
- `HRDATA` in HDATA_SIZE, `HREADY` in 1, `HRESP` in 1: AHB-Lite slave responses

## Operation
- States:
  - IDLE: arbitrate; on any `req_valid`, assert `req_ready[w]` combinationally and latch the winner's fields and index at the edge.
    - Legal request → ADDR.
    - Illegal request → RSP_ERR.
  - ADDR: drive HSEL=1, HTRANS=NONSEQ, HADDR, HWRITE and HSIZE from the latch. Hold until an edge with HREADY=1, then → DATA.
  - DATA: drive HTRANS=IDLE and HSEL=0; for writes, HWDATA = latched wdata (held through wait states).
    - Edge with HREADY=1, HRESP=0: capture HRDATA into `rsp_rdata`, → IDLE, pulse `rsp_valid[w]` with `rsp_err`=0.
    - HRESP=1 with HREADY=0: → ERR.
  - ERR: wait for HREADY=1, then → IDLE, pulse `rsp_valid[w]` with `rsp_err`=1.
  - RSP_ERR: no bus activity; → IDLE, pulse `rsp_valid[w]` with `rsp_err`=1.
- Illegal request: HSIZE > log2(HDATA_SIZE/8), or address not aligned to the size.
- Constant outputs: HBURST=SINGLE (000), HPROT=4'b0011, HMASTLOCK=0.
- One outstanding transfer at a time; other requesters stay stalled (`req_ready`=0) until IDLE.
- `rsp_rdata` holds its last value; it is updated only on a successful read. Writes leave it unchanged.
- Reset mid-operation drops the transfer with no response; requesters must reissue.

## Timing
- Reset values: all outputs 0, except `HPROT`=4'b0011. `HTRANS`=IDLE. Round-robin pointer=NUM_REQ-1, so requester 0 is first.
- Zero-wait transfer:
  - Edge 0: accept.
  - Cycle 1: address phase.
  - Cycle 2: data phase.
  - Cycle 3: `rsp_valid` high and IDLE; a new accept is possible in cycle 3.
  - Throughput: one transfer per 3 cycles.
- Each HREADY-low cycle in ADDR or DATA adds one cycle of latency.
- `rsp_valid` and `req_ready` are single-cycle pulses; `req_valid` must hold until `req_ready`.
- Error response adds exactly one cycle versus OKAY with zero wait states.

## Configuration
- `AHB_ARB_RR_EN` defined: round-robin arbitration. Search starts at (last granted + 1) mod NUM_REQ; the pointer updates only on accept.
- Undefined: fixed priority, lowest index wins; the pointer logic is not built.

## Structure
- Package `ahb3lite_pkg`:
  - `htrans_t` (IDLE/BUSY/NONSEQ/SEQ)
  - HSIZE constants (BYTE/HALF/WORD/DWORD)
  - `HBURST_SINGLE`, `HPROT_DEFAULT`
  - `arb_state_t` (IDLE/ADDR/DATA/ERR/RSP_ERR)
- Sub-module `ahb_req_arbiter`: `req_valid` plus pointer → one-hot grant and index. It contains the round-robin/fixed selection under the macro and holds the pointer register.

## Test plan
- Single write then read: requester 0 writes 32'hCAFE_BABE to 0x0000 with size 010, HREADY=1.
  - Write: NONSEQ in cycle 1, HWDATA=CAFE_BABE in cycle 2, `rsp_valid[0]` in cycle 3 with `rsp_err`=0.
  - Read of 0x0000: `rsp_rdata`=32'hCAFE_BABE.
- Contention: both requesters hold `req_valid` for 4 transfers.
  - With `AHB_ARB_RR_EN`: grant order 0,1,0,1.
  - Without it: 0,0,0,0.
- Wait states: HREADY low for 3 cycles in the data phase of a write to 0x0004 with 32'hDEAD_BEEF.
  - HWDATA held stable throughout.
  - `rsp_valid` 3 cycles later than the zero-wait case.
- Error: slave returns HRESP=1/HREADY=0, then HRESP=1/HREADY=1.
  - `rsp_err`=1 one cycle after the second error cycle.
  - No second NONSEQ is issued.
- Misaligned: word request to 0x0002 → no NONSEQ on the bus; `rsp_valid` with `rsp_err`=1 the cycle after accept.
- Reset in the DATA state: HRESETn low asynchronously.
  - All outputs at reset values immediately.
  - No `rsp_valid`.
  - After release, requester 0 is granted first.
